// File: rtl/glyph_pkg.sv
// Shared glyph geometry defaults and the pixel-order helper used by the fetcher and serialisers.
package glyph_pkg;

  localparam int GLYPH_WIDTH  = 8;
  localparam int GLYPH_HEIGHT = 16;
  localparam int GLYPH_COUNT  = 256;
  localparam int GLYPH_UCP_W  = 21;
  localparam int GLYPH_TAG_W  = 8;
  localparam int GLYPH_MAX_W  = 64;

  // Reverses the low 'width' bits of v; bits at and above 'width' come back as 0.
  function automatic logic [GLYPH_MAX_W-1:0] glyph_bitrev(input logic [GLYPH_MAX_W-1:0] v,
                                                          input int width);
    logic [GLYPH_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < GLYPH_MAX_W; i++) begin
      if (i < width) r[6'(i)] = v[6'(width - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/glyph_line_fetch_if.sv
// Request/response bundle of the glyph line fetcher.
// Handshake: a beat transfers on a rising edge where valid && ready; the source holds its payload
// and valid until that edge, and ready may depend combinationally on downstream state.
interface glyph_line_fetch_if #(
  parameter int WIDTH  = 8,
  parameter int LINE_W = 4,
  parameter int UCP_W  = 21,
  parameter int TAG_W  = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [UCP_W-1:0]  in_ucp;
  logic [LINE_W-1:0] in_line;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_line;
  logic [TAG_W-1:0]  out_tag;
  logic              out_miss;

  modport master (
    output in_valid, in_ucp, in_line, in_tag, out_ready,
    input  in_ready, out_valid, out_line, out_tag, out_miss
  );

  modport slave (
    input  in_valid, in_ucp, in_line, in_tag, out_ready,
    output in_ready, out_valid, out_line, out_tag, out_miss
  );

endinterface

// File: rtl/rom_sync.sv
// Synchronous-read ROM. The contents are the address pattern word[a] = a,
// which doubles as a self-describing test font.
module rom_sync #(
  parameter int    WIDTH  = 8,
  parameter int    DEPTH  = 4096,
  parameter string INIT_F = ""
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  output logic [WIDTH-1:0]         o_data
);

  always_ff @(posedge clk) begin
    o_data <= WIDTH'(i_addr);
  end

endmodule

// File: rtl/glyph_line_fetch.sv
// Streaming glyph-line fetcher: code point + line -> one line of pixels, 3-stage pipe, 1 line/clock.
// Optional GLYPH_LINE_FETCH_MISS_CNT_EN adds a saturating miss_cnt output.
module glyph_line_fetch
  import glyph_pkg::*;
#(
  parameter int    WIDTH       = GLYPH_WIDTH,
  parameter int    HEIGHT      = GLYPH_HEIGHT,
  parameter int    COUNT       = GLYPH_COUNT,
  parameter int    OFFSET      = 0,
  parameter int    REPLACE_IDX = 0,
  parameter int    UCP_W       = GLYPH_UCP_W,
  parameter int    TAG_W       = GLYPH_TAG_W,
  parameter string FONT_FILE   = "",
  parameter bit    LSB         = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  glyph_line_fetch_if.slave bus
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
  ,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int LINE_W = $clog2(HEIGHT);
  localparam int DEPTH  = HEIGHT * COUNT;
  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic w_adv;

  logic signed [UCP_W:0] w_idx_s;
  logic                  w_miss;
  logic                  w_blank;
  logic [IDX_W-1:0]      w_idx;
  logic [LINE_W-1:0]     w_line_eff;
  logic [AW-1:0]         w_addr;

  logic              r_s1_vld;
  logic [AW-1:0]     r_s1_addr;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s1_miss;
  logic              r_s1_blank;

  logic              r_s2_vld;
  logic [AW-1:0]     r_s2_addr;
  logic [TAG_W-1:0]  r_s2_tag;
  logic              r_s2_miss;
  logic              r_s2_blank;

  logic [AW-1:0]     w_rom_addr;
  logic [WIDTH-1:0]  w_rom_data;
  logic [WIDTH-1:0]  w_conv;

  logic              r_out_vld;
  logic [WIDTH-1:0]  r_out_line;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_miss;

  assign w_adv        = !r_out_vld || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Signed difference so code points below OFFSET show up as negative rather than wrapping.
  assign w_idx_s    = $signed({1'b0, bus.in_ucp}) - $signed((UCP_W + 1)'(OFFSET));
  assign w_miss     = w_idx_s[UCP_W] || (w_idx_s >= $signed((UCP_W + 1)'(COUNT)));
  assign w_idx      = w_miss ? IDX_W'(REPLACE_IDX) : w_idx_s[IDX_W-1:0];
  assign w_blank    = ({1'b0, bus.in_line} >= (LINE_W + 1)'(HEIGHT));
  assign w_line_eff = w_blank ? '0 : bus.in_line;
  assign w_addr     = AW'(w_idx) * AW'(HEIGHT) + AW'(w_line_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_tag   <= '0;
      r_s1_miss  <= 1'b0;
      r_s1_blank <= 1'b0;
    end else if (w_adv) begin
      r_s1_vld   <= bus.in_valid;
      r_s1_addr  <= w_addr;
      r_s1_tag   <= bus.in_tag;
      r_s1_miss  <= w_miss;
      r_s1_blank <= w_blank;
    end
  end

  // During a stall the ROM re-reads the address whose word already sits in S2, so the
  // registered ROM output stays aligned with the held S2 sideband without a read enable.
  assign w_rom_addr = w_adv ? r_s1_addr : r_s2_addr;

  rom_sync #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .INIT_F (FONT_FILE)
  ) u_rom (
    .clk    (clk),
    .i_addr (w_rom_addr),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld   <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_tag   <= '0;
      r_s2_miss  <= 1'b0;
      r_s2_blank <= 1'b0;
    end else if (w_adv) begin
      r_s2_vld   <= r_s1_vld;
      r_s2_addr  <= r_s1_addr;
      r_s2_tag   <= r_s1_tag;
      r_s2_miss  <= r_s1_miss;
      r_s2_blank <= r_s1_blank;
    end
  end

  // Output bit 0 is always the left-most pixel; MSB-left fonts get reversed here.
  assign w_conv = LSB ? w_rom_data : WIDTH'(glyph_bitrev(GLYPH_MAX_W'(w_rom_data), WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld  <= 1'b0;
      r_out_line <= '0;
      r_out_tag  <= '0;
      r_out_miss <= 1'b0;
    end else if (w_adv) begin
      r_out_vld  <= r_s2_vld;
      r_out_line <= r_s2_blank ? '0 : w_conv;
      r_out_tag  <= r_s2_tag;
      r_out_miss <= r_s2_miss;
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_line  = r_out_line;
  assign bus.out_tag   = r_out_tag;
  assign bus.out_miss  = r_out_miss;

`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
    end else if (r_out_vld && bus.out_ready && r_out_miss && (r_miss_cnt != 16'hFFFF)) begin
      r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_glyph_line_fetch.sv
// Self-checking bench for glyph_line_fetch with a scoreboard on the main instance and a
// HEIGHT=12 instance for blank-line cases.
module tb_glyph_line_fetch;

  localparam int W   = 8;
  localparam int H   = 16;
  localparam int H_B = 12;
  localparam int CNT = 128;
  localparam int OFS = 32;
  localparam int UW  = 21;
  localparam int TW  = 8;
  localparam int LW  = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  glyph_line_fetch_if #(.WIDTH(W), .LINE_W(LW), .UCP_W(UW), .TAG_W(TW)) bus ();
  glyph_line_fetch_if #(.WIDTH(W), .LINE_W(LW), .UCP_W(UW), .TAG_W(TW)) bus_b ();

`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
  logic [15:0] miss_cnt;
  logic [15:0] miss_cnt_b;
`endif

  glyph_line_fetch #(
    .WIDTH(W), .HEIGHT(H), .COUNT(CNT), .OFFSET(OFS), .REPLACE_IDX(0),
    .UCP_W(UW), .TAG_W(TW), .FONT_FILE(""), .LSB(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    , .miss_cnt(miss_cnt)
`endif
  );

  glyph_line_fetch #(
    .WIDTH(W), .HEIGHT(H_B), .COUNT(CNT), .OFFSET(OFS), .REPLACE_IDX(0),
    .UCP_W(UW), .TAG_W(TW), .FONT_FILE(""), .LSB(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    , .miss_cnt(miss_cnt_b)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [16:0] exp_q[$];
  int n_resp = 0;
  int model_miss_cnt = 0;
  bit stream_chk = 1'b0;
  bit have_last = 1'b0;
  int last_cyc = 0;
  bit hold_pend = 1'b0;
  logic [16:0] hold_val;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {miss, tag, pixels}; font word[a] = a[7:0], MSB-left, so pixels are reversed.
  function automatic logic [16:0] model(input logic [20:0] ucp, input logic [3:0] line,
                                        input logic [7:0] tag, input int height);
    logic miss;
    int idx;
    int addr;
    logic [7:0] word;
    logic [7:0] pix;
    miss = (int'(ucp) < OFS) || (int'(ucp) - OFS >= CNT);
    idx  = miss ? 0 : int'(ucp) - OFS;
    addr = idx * height + ((int'(line) >= height) ? 0 : int'(line));
    word = addr[7:0];
    pix  = {word[0], word[1], word[2], word[3], word[4], word[5], word[6], word[7]};
    if (int'(line) >= height) pix = 8'h00;
    return {miss, tag, pix};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [16:0] exp;
    if (rst_n) begin
      check_eq("in_ready_adv", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
      if (hold_pend)
        check_eq("stall_hold", {bus.out_valid, bus.out_miss, bus.out_tag, bus.out_line}, {1'b1, hold_val});
      hold_pend = bus.out_valid && !bus.out_ready;
      hold_val  = {bus.out_miss, bus.out_tag, bus.out_line};
      if (bus.out_valid && bus.out_ready) begin
        check_eq("resp_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check_eq("resp", {bus.out_miss, bus.out_tag, bus.out_line}, exp);
          if (exp[16]) model_miss_cnt++;
          n_resp++;
          if (stream_chk && have_last) check_eq("stream_gap", 64'(cyc - last_cyc), 64'd1);
          have_last = 1'b1;
          last_cyc  = cyc;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_ucp, bus.in_line, bus.in_tag, H));
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [20:0] ucp, input logic [3:0] line, input logic [7:0] tag);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_ucp   = ucp;
    bus.in_line  = line;
    bus.in_tag   = tag;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    check_eq("drain", 64'(exp_q.size()), 64'd0);
    tick(1);
  endtask

  // Single request on the HEIGHT=12 instance; out_ready_b is held at 1.
  task automatic probe_b(input string tag, input logic [20:0] ucp, input logic [3:0] line,
                         input logic [7:0] t);
    logic [16:0] exp;
    exp = model(ucp, line, t, H_B);
    bus_b.in_valid = 1'b1;
    bus_b.in_ucp   = ucp;
    bus_b.in_line  = line;
    bus_b.in_tag   = t;
    check_eq({tag, "_in_ready"}, 64'(bus_b.in_ready), 64'd1);
    tick(1);
    bus_b.in_valid = 1'b0;
    tick(1);
    check_eq({tag, "_early"}, 64'(bus_b.out_valid), 64'd0);
    tick(1);
    check_eq(tag, {bus_b.out_valid, bus_b.out_miss, bus_b.out_tag, bus_b.out_line}, {1'b1, exp});
    tick(1);
  endtask

  task automatic latency_probe(input string tag, input logic [20:0] ucp, input logic [3:0] line,
                               input logic [7:0] t, input logic [7:0] exp_line);
    send(ucp, line, t);
    idle();
    check_eq({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    tick(1);
    check_eq({tag, "_lat2"}, 64'(bus.out_valid), 64'd0);
    tick(1);
    check_eq({tag, "_lat3"}, {bus.out_valid, bus.out_miss, bus.out_tag, bus.out_line},
             {1'b1, 1'b0, t, exp_line});
    drain();
  endtask

  // ---------------- main sequence ----------------
  int pat[4] = '{1, 0, 0, 1};
  int n0;

  initial begin
    bus.in_valid = 1'b0; bus.in_ucp = '0; bus.in_line = '0; bus.in_tag = '0; bus.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_ucp = '0; bus_b.in_line = '0; bus_b.in_tag = '0;
    bus_b.out_ready = 1'b1;

    tick(3);
    check_eq("rst_out", {bus.out_valid, bus.out_miss, bus.out_tag, bus.out_line}, 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    check_eq("rst_miss_cnt", 64'(miss_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);

    // Basic lookup: 0x41 line 3 -> addr 531, word 0x13 -> 0xC8.
    latency_probe("basic", 21'h41, 4'd3, 8'h5A, 8'hC8);

    // Streaming, 20 back-to-back.
    n0 = n_resp;
    stream_chk = 1'b1;
    have_last  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_eq("stream_in_ready", 64'(bus.in_ready), 64'd1);
      send(21'(32'h20 + i), 4'd0, 8'(i));
    end
    idle();
    drain();
    stream_chk = 1'b0;
    check_eq("stream_count", 64'(n_resp - n0), 64'd20);

    // Backpressure: out_ready 1,0,0,1 repeating during a 6-request stream.
    n0 = n_resp;
    fork
      begin
        for (int i = 0; i < 6; i++) send(21'(32'h50 + i), 4'(i), 8'(8'h80 + i));
        idle();
      end
      begin
        for (int k = 0; k < 24; k++) begin
          bus.out_ready = pat[k % 4][0];
          tick(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check_eq("bp_count", 64'(n_resp - n0), 64'd6);

    // Out of range both sides, plus the in-range edges.
    n0 = model_miss_cnt;
    send(21'h1F, 4'd5, 8'hA1);
    send(21'hA0, 4'd9, 8'hA2);
    send(21'h9F, 4'd2, 8'hA3);
    send(21'h20, 4'd15, 8'hA4);
    send(21'h1FFFFF, 4'd1, 8'hA5);
    idle();
    drain();
    check_eq("oor_miss_count", 64'(model_miss_cnt - n0), 64'd3);
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    check_eq("miss_cnt", 64'(miss_cnt), 64'(model_miss_cnt));
`endif

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++)
          send(21'($urandom_range(8'hB0, 8'h10)), 4'($urandom_range(15, 0)), 8'($urandom_range(255, 0)));
        idle();
      end
      begin
        for (int k = 0; k < 90; k++) begin
          bus.out_ready = ($urandom_range(3, 0) != 0);
          tick(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    check_eq("miss_cnt_rand", 64'(miss_cnt), 64'(model_miss_cnt));
`endif

    // Blank lines on the HEIGHT=12 instance.
    probe_b("blank13", 21'h41, 4'd13, 8'h11);
    probe_b("line11", 21'h41, 4'd11, 8'h12);
    probe_b("blank12_miss", 21'h10, 4'd12, 8'h13);
    probe_b("line0", 21'h22, 4'd0, 8'h14);

    // Reset with three requests in flight.
    send(21'h30, 4'd1, 8'hC1);
    send(21'h31, 4'd2, 8'hC2);
    send(21'h32, 4'd3, 8'hC3);
    idle();
    check_eq("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    exp_q.delete();
    model_miss_cnt = 0;
    #1;
    check_eq("async_reset_valid", 64'(bus.out_valid), 64'd0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check_eq("no_stale", 64'(bus.out_valid), 64'd0);
    end
    // 0x33 line 7: idx 19 -> addr 311 -> word 0x37 -> 0xEC.
    latency_probe("post_reset", 21'h33, 4'd7, 8'hD1, 8'hEC);
`ifdef GLYPH_LINE_FETCH_MISS_CNT_EN
    check_eq("miss_cnt_after_reset", 64'(miss_cnt), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
